// File: rtl/sequential_bcd_converter_if.sv
// Handshake and data bundle for the sequential binary/BCD converter.
// The master side issues requests and consumes results; the slave side is the converter.

`ifndef BINARY_TO_BCD_WIDTH
// Decimal digits needed for a w-bit unsigned value: ceil(w * log10(2)).
`define BINARY_TO_BCD_WIDTH(w) ((((w) * 30103) + 99999) / 100000)
`endif

interface sequential_bcd_converter_if #(
    parameter int WIDTH_BINARY = 16,
    parameter int WIDTH_BCD    = `BINARY_TO_BCD_WIDTH(WIDTH_BINARY) * 4
);
    logic                    input_valid;
    logic                    input_ready;
    logic                    input_mode;
    logic [WIDTH_BINARY-1:0] input_binary;
    logic [WIDTH_BCD-1:0]    input_bcd;
    logic                    output_valid;
    logic                    output_ready;
    logic                    output_mode;
    logic [WIDTH_BINARY-1:0] output_binary;
    logic [WIDTH_BCD-1:0]    output_bcd;
    logic                    output_invalid_digit;
    logic                    output_overflow;

    modport master (
        output input_valid, input_mode, input_binary, input_bcd, output_ready,
        input  input_ready, output_valid, output_mode, output_binary, output_bcd,
               output_invalid_digit, output_overflow
    );

    modport slave (
        input  input_valid, input_mode, input_binary, input_bcd, output_ready,
        output input_ready, output_valid, output_mode, output_binary, output_bcd,
               output_invalid_digit, output_overflow
    );
endinterface

// File: rtl/sequential_bcd_converter.sv
// Multi-cycle bidirectional binary/BCD converter.
// Mode 0: double dabble (add 3 to digits >= 5, shift left), one bit per cycle.
// Mode 1: reverse double dabble (shift right, subtract 3 from digits >= 8), one bit per cycle.

`ifndef BINARY_TO_BCD_WIDTH
`define BINARY_TO_BCD_WIDTH(w) ((((w) * 30103) + 99999) / 100000)
`endif

module sequential_bcd_converter #(
    parameter int WIDTH_BINARY = 16,
    parameter int WIDTH_BCD    = `BINARY_TO_BCD_WIDTH(WIDTH_BINARY) * 4
) (
    input logic                     clock,
    input logic                     resetn,
    sequential_bcd_converter_if.slave bus
);

    localparam int DIGITS = WIDTH_BCD / 4;
    localparam int CNT_W  = $clog2(WIDTH_BINARY + 1);
    localparam int WORK_W = WIDTH_BCD + WIDTH_BINARY;

    if (WIDTH_BINARY < 1) begin : g_bad_binary_width
        $fatal(1, "WIDTH_BINARY must be at least 1");
    end
    if ((WIDTH_BCD % 4) != 0) begin : g_bad_bcd_multiple
        $fatal(1, "WIDTH_BCD must be a multiple of 4");
    end
    if (WIDTH_BCD < `BINARY_TO_BCD_WIDTH(WIDTH_BINARY) * 4) begin : g_bad_bcd_width
        $fatal(1, "WIDTH_BCD too small for WIDTH_BINARY");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    mode_q, mode_d;
    logic                    invalid_q, invalid_d;
    logic [WIDTH_BCD-1:0]    bcd_acc_q, bcd_acc_d;
    logic [WIDTH_BINARY-1:0] bin_acc_q, bin_acc_d;
    logic [WIDTH_BINARY-1:0] echo_bin_q, echo_bin_d;
    logic [WIDTH_BCD-1:0]    echo_bcd_q, echo_bcd_d;
    logic [WORK_W-1:0]       work;

    function automatic logic [WIDTH_BCD-1:0] add3_digits(input logic [WIDTH_BCD-1:0] a);
        logic [WIDTH_BCD-1:0] r;
        r = a;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [WIDTH_BCD-1:0] sub3_digits(input logic [WIDTH_BCD-1:0] a);
        logic [WIDTH_BCD-1:0] r;
        r = a;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd8) r[4*i +: 4] = r[4*i +: 4] - 4'd3;
        end
        return r;
    endfunction

    function automatic logic any_digit_invalid(input logic [WIDTH_BCD-1:0] a);
        logic bad;
        bad = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // Next-state logic: accept in IDLE, iterate once per cycle in BUSY, hold in DONE.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        mode_d     = mode_q;
        invalid_d  = invalid_q;
        bcd_acc_d  = bcd_acc_q;
        bin_acc_d  = bin_acc_q;
        echo_bin_d = echo_bin_q;
        echo_bcd_d = echo_bcd_q;
        work       = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.input_valid) begin
                    state_d    = S_BUSY;
                    count_d    = '0;
                    mode_d     = bus.input_mode;
                    echo_bin_d = bus.input_binary;
                    echo_bcd_d = bus.input_bcd;
                    if (bus.input_mode) begin
                        bcd_acc_d = bus.input_bcd;
                        bin_acc_d = '0;
                        invalid_d = any_digit_invalid(bus.input_bcd);
                    end else begin
                        bcd_acc_d = '0;
                        bin_acc_d = bus.input_binary;
                        invalid_d = 1'b0;
                    end
                end
            end
            S_BUSY: begin
                // bin_acc doubles as the shift-out source in mode 0 and the result sink in mode 1.
                if (mode_q) begin
                    work      = {bcd_acc_q, bin_acc_q} >> 1;
                    bcd_acc_d = sub3_digits(work[WIDTH_BINARY +: WIDTH_BCD]);
                    bin_acc_d = work[WIDTH_BINARY-1:0];
                end else begin
                    work      = {add3_digits(bcd_acc_q), bin_acc_q} << 1;
                    bcd_acc_d = work[WIDTH_BINARY +: WIDTH_BCD];
                    bin_acc_d = work[WIDTH_BINARY-1:0];
                end
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH_BINARY - 1)) state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.output_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            mode_q     <= 1'b0;
            invalid_q  <= 1'b0;
            bcd_acc_q  <= '0;
            bin_acc_q  <= '0;
            echo_bin_q <= '0;
            echo_bcd_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            mode_q     <= mode_d;
            invalid_q  <= invalid_d;
            bcd_acc_q  <= bcd_acc_d;
            bin_acc_q  <= bin_acc_d;
            echo_bin_q <= echo_bin_d;
            echo_bcd_q <= echo_bcd_d;
        end
    end

    // Result outputs are gated by DONE so they read zero outside a valid result.
    always_comb begin
        bus.input_ready          = (state_q == S_IDLE);
        bus.output_valid         = (state_q == S_DONE);
        bus.output_mode          = 1'b0;
        bus.output_binary        = '0;
        bus.output_bcd           = '0;
        bus.output_invalid_digit = 1'b0;
        bus.output_overflow      = 1'b0;
        if (state_q == S_DONE) begin
            bus.output_mode          = mode_q;
            bus.output_binary        = mode_q ? bin_acc_q : echo_bin_q;
            bus.output_bcd           = mode_q ? echo_bcd_q : bcd_acc_q;
            bus.output_invalid_digit = mode_q & invalid_q;
            bus.output_overflow      = mode_q & (bcd_acc_q != '0);
        end
    end

endmodule

// File: tb/tb_sequential_bcd_converter.sv
// Directed bench for sequential_bcd_converter at WIDTH_BINARY = 1, 8 and 16.

module tb_sequential_bcd_converter;

    logic clock;
    logic resetn;
    int   checks;
    int   errors;

    sequential_bcd_converter_if #(.WIDTH_BINARY(1),  .WIDTH_BCD(4))  bif1 ();
    sequential_bcd_converter_if #(.WIDTH_BINARY(8),  .WIDTH_BCD(12)) bif8 ();
    sequential_bcd_converter_if #(.WIDTH_BINARY(16), .WIDTH_BCD(20)) bif16 ();

    sequential_bcd_converter #(.WIDTH_BINARY(1), .WIDTH_BCD(4)) u_dut1 (
        .clock(clock), .resetn(resetn), .bus(bif1));
    sequential_bcd_converter #(.WIDTH_BINARY(8), .WIDTH_BCD(12)) u_dut8 (
        .clock(clock), .resetn(resetn), .bus(bif8));
    sequential_bcd_converter #(.WIDTH_BINARY(16), .WIDTH_BCD(20)) u_dut16 (
        .clock(clock), .resetn(resetn), .bus(bif16));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int          t;
        r = '0;
        t = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic rdy(input int sel);
        case (sel)
            1:       return bif1.input_ready;
            8:       return bif8.input_ready;
            default: return bif16.input_ready;
        endcase
    endfunction

    function automatic logic vld(input int sel);
        case (sel)
            1:       return bif1.output_valid;
            8:       return bif8.output_valid;
            default: return bif16.output_valid;
        endcase
    endfunction

    task automatic set_req(input int sel, input logic v, input logic m,
                           input logic [15:0] b, input logic [19:0] d);
        case (sel)
            1: begin
                bif1.input_valid = v; bif1.input_mode = m;
                bif1.input_binary = b[0:0]; bif1.input_bcd = d[3:0];
            end
            8: begin
                bif8.input_valid = v; bif8.input_mode = m;
                bif8.input_binary = b[7:0]; bif8.input_bcd = d[11:0];
            end
            default: begin
                bif16.input_valid = v; bif16.input_mode = m;
                bif16.input_binary = b; bif16.input_bcd = d;
            end
        endcase
    endtask

    task automatic set_ordy(input int sel, input logic v);
        case (sel)
            1:       bif1.output_ready = v;
            8:       bif8.output_ready = v;
            default: bif16.output_ready = v;
        endcase
    endtask

    // Issues one request and waits (bounded) for output_valid; the result is left pending.
    task automatic convert(input int sel, input logic m, input logic [15:0] b, input logic [19:0] d,
                           output int lat, output logic [15:0] ob, output logic [19:0] od,
                           output logic inv, output logic ovf);
        int g;
        g = 0;
        @(negedge clock);
        while (!rdy(sel) && g < 100) begin
            @(negedge clock);
            g++;
        end
        check("accept_ready", 32'(rdy(sel)), 32'd1);
        set_req(sel, 1'b1, m, b, d);
        @(posedge clock);
        #1;
        set_req(sel, 1'b0, ~m, ~b, ~d);
        lat = 0;
        while (!vld(sel) && lat < 200) begin
            @(posedge clock);
            #1;
            lat++;
        end
        case (sel)
            1: begin
                ob = 16'(bif1.output_binary); od = 20'(bif1.output_bcd);
                inv = bif1.output_invalid_digit; ovf = bif1.output_overflow;
            end
            8: begin
                ob = 16'(bif8.output_binary); od = 20'(bif8.output_bcd);
                inv = bif8.output_invalid_digit; ovf = bif8.output_overflow;
            end
            default: begin
                ob = bif16.output_binary; od = bif16.output_bcd;
                inv = bif16.output_invalid_digit; ovf = bif16.output_overflow;
            end
        endcase
    endtask

    task automatic release_out(input int sel);
        set_ordy(sel, 1'b1);
        @(posedge clock);
        #1;
        set_ordy(sel, 1'b0);
    endtask

    int          lat;
    logic [15:0] ob;
    logic [19:0] od;
    logic        inv;
    logic        ovf;

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        for (int s = 0; s < 3; s++) begin
            set_req((s == 0) ? 1 : (s == 1) ? 8 : 16, 1'b0, 1'b0, '0, '0);
            set_ordy((s == 0) ? 1 : (s == 1) ? 8 : 16, 1'b0);
        end
        #23;
        check("rst_in_ready", 32'(bif8.input_ready), 32'd1);
        check("rst_out_valid", 32'(bif8.output_valid), 32'd0);
        check("rst_out_bcd", 32'(bif8.output_bcd), 32'd0);
        check("rst_out_bin", 32'(bif8.output_binary), 32'd0);
        @(negedge clock);
        resetn = 1'b1;

        // output_ready with nothing pending must be ignored
        set_ordy(8, 1'b1);
        repeat (3) @(posedge clock);
        #1;
        check("idle_ordy_valid", 32'(bif8.output_valid), 32'd0);
        check("idle_ordy_ready", 32'(bif8.input_ready), 32'd1);
        set_ordy(8, 1'b0);

        // Mode 0, 255
        convert(8, 1'b0, 16'd255, 20'h0, lat, ob, od, inv, ovf);
        check("m0_255_lat", lat, 32'd8);
        check("m0_255_bcd", od, 32'h255);
        check("m0_255_bin", ob, 32'hFF);
        check("m0_255_flags", {inv, ovf}, 32'd0);
        check("m0_255_mode", 32'(bif8.output_mode), 32'd0);
        release_out(8);

        // Mode 1 directed
        convert(8, 1'b1, 16'h0, 20'h128, lat, ob, od, inv, ovf);
        check("m1_128_lat", lat, 32'd8);
        check("m1_128_bin", ob, 32'h80);
        check("m1_128_flags", {inv, ovf}, 32'd0);
        check("m1_128_echo", od, 32'h128);
        check("m1_128_mode", 32'(bif8.output_mode), 32'd1);
        release_out(8);
        convert(8, 1'b1, 16'h0, 20'h999, lat, ob, od, inv, ovf);
        check("m1_999_bin", ob, 32'hE7);
        check("m1_999_ovf", ovf, 32'd1);
        check("m1_999_inv", inv, 32'd0);
        release_out(8);
        convert(8, 1'b1, 16'h0, 20'h1A0, lat, ob, od, inv, ovf);
        check("m1_1a0_inv", inv, 32'd1);
        release_out(8);

        // Exhaustive round trip at 8 bits
        for (int v = 0; v < 256; v++) begin
            convert(8, 1'b0, 16'(v), 20'h0, lat, ob, od, inv, ovf);
            check("rt_bcd", od, 32'(to_bcd(v)));
            for (int k = 0; k < 3; k++) check("rt_digit_le9", 32'(od[4*k +: 4] <= 4'd9), 32'd1);
            release_out(8);
            convert(8, 1'b1, 16'h0, od, lat, ob, od, inv, ovf);
            check("rt_bin", ob, 32'(v));
            check("rt_flags", {inv, ovf}, 32'd0);
            release_out(8);
        end

        // Backpressure: result held for 20 cycles
        convert(8, 1'b0, 16'd77, 20'h0, lat, ob, od, inv, ovf);
        for (int c = 0; c < 20; c++) begin
            @(posedge clock);
            #1;
            check("bp_valid", 32'(bif8.output_valid), 32'd1);
            check("bp_bcd", 32'(bif8.output_bcd), 32'h077);
            check("bp_bin", 32'(bif8.output_binary), 32'd77);
            check("bp_in_ready", 32'(bif8.input_ready), 32'd0);
        end
        release_out(8);
        check("bp_post_ready", 32'(bif8.input_ready), 32'd1);
        check("bp_post_valid", 32'(bif8.output_valid), 32'd0);
        convert(8, 1'b0, 16'd3, 20'h0, lat, ob, od, inv, ovf);
        check("bp_next_bcd", od, 32'h003);
        release_out(8);

        // Reset during iteration 4 of 8
        @(negedge clock);
        set_req(8, 1'b1, 1'b0, 16'd123, 20'h0);
        @(posedge clock);
        #1;
        set_req(8, 1'b0, 1'b0, 16'd0, 20'h0);
        repeat (4) @(posedge clock);
        #1;
        resetn = 1'b0;
        #1;
        check("midrst_ready", 32'(bif8.input_ready), 32'd1);
        check("midrst_valid", 32'(bif8.output_valid), 32'd0);
        check("midrst_bcd", 32'(bif8.output_bcd), 32'd0);
        check("midrst_bin", 32'(bif8.output_binary), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clock);
            #1;
            check("midrst_no_valid", 32'(bif8.output_valid), 32'd0);
        end
        convert(8, 1'b0, 16'd42, 20'h0, lat, ob, od, inv, ovf);
        check("midrst_next_bcd", od, 32'h042);
        release_out(8);

        // 16-bit directed
        convert(16, 1'b0, 16'd65535, 20'h0, lat, ob, od, inv, ovf);
        check("w16_lat", lat, 32'd16);
        check("w16_65535_bcd", od, 32'h65535);
        release_out(16);
        convert(16, 1'b0, 16'd12345, 20'h0, lat, ob, od, inv, ovf);
        check("w16_12345_bcd", od, 32'h12345);
        release_out(16);
        convert(16, 1'b1, 16'h0, 20'h65535, lat, ob, od, inv, ovf);
        check("w16_m1_ffff", ob, 32'hFFFF);
        check("w16_m1_ffff_flags", {inv, ovf}, 32'd0);
        release_out(16);
        convert(16, 1'b1, 16'h0, 20'h99999, lat, ob, od, inv, ovf);
        check("w16_m1_99999_bin", ob, 32'h869F);
        check("w16_m1_99999_ovf", ovf, 32'd1);
        release_out(16);
        convert(16, 1'b1, 16'h0, 20'h65536, lat, ob, od, inv, ovf);
        check("w16_m1_65536_bin", ob, 32'h0);
        check("w16_m1_65536_ovf", ovf, 32'd1);
        release_out(16);
        convert(16, 1'b1, 16'h0, 20'h0000F, lat, ob, od, inv, ovf);
        check("w16_m1_inv", inv, 32'd1);
        release_out(16);

        // 1-bit boundary
        convert(1, 1'b0, 16'd1, 20'h0, lat, ob, od, inv, ovf);
        check("w1_lat", lat, 32'd1);
        check("w1_m0_bcd", od, 32'h1);
        release_out(1);
        convert(1, 1'b1, 16'h0, 20'h1, lat, ob, od, inv, ovf);
        check("w1_m1_1", {ob[0], inv, ovf}, 32'b100);
        release_out(1);
        convert(1, 1'b1, 16'h0, 20'h2, lat, ob, od, inv, ovf);
        check("w1_m1_2", {ob[0], inv, ovf}, 32'b001);
        release_out(1);
        convert(1, 1'b1, 16'h0, 20'h3, lat, ob, od, inv, ovf);
        check("w1_m1_3", {ob[0], inv, ovf}, 32'b101);
        release_out(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
